dac_cmd_rx: RTL and testbench

DAC_CMD_RX -- requirements
Module: dac_cmd_rx

---
 rtl/dac_pkg.sv | 36 +++
 rtl/spi_sync_edge.sv | 33 +++
 rtl/dac_cmd_rx.sv | 168 ++++++++++++++++
 tb/tb_dac_cmd_rx.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_pkg.sv
// Shared constants and types for the DAC command receiver: frame layout,
// opcode encoding and receiver FSM states.
package dac_pkg;

    localparam int unsigned CH_NUM    = 3;
    localparam int unsigned DAC_W     = 12;
    localparam int unsigned FRAME_LEN = 16;
    localparam int unsigned MIDSCALE  = 2048;

    localparam int unsigned CH_W = 2;
    localparam int unsigned OP_W = 2;

    // Channel field value that addresses every shadow register at once
    localparam logic [CH_W-1:0] CH_BCAST = CH_W'(3);

    typedef enum logic [OP_W-1:0] {
        OP_WR        = 2'b00,
        OP_WR_COMMIT = 2'b01,
        OP_COMMIT    = 2'b10,
        OP_MID       = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        CHECK  = 2'd2,
        COMMIT = 2'd3
    } state_e;

    typedef struct packed {
        logic [CH_W-1:0]  ch;
        op_e              op;
        logic [DAC_W-1:0] value;
    } frame_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for one asynchronous SPI line, plus edge pulses
// derived from the synchronized level and its one-cycle-delayed copy.
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_core,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic rise_c,
    output logic fall_c
);

    logic meta_q;
    logic prev_q;

    // Reset to the line's idle level so release from reset never looks like an edge
    always_ff @(posedge clk_core or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            dout   <= RST_VAL;
            prev_q <= RST_VAL;
        end else begin
            meta_q <= din;
            dout   <= meta_q;
            prev_q <= dout;
        end
    end

    assign rise_c = dout & ~prev_q;
    assign fall_c = ~dout & prev_q;

endmodule

// File: rtl/dac_cmd_rx.sv
// SPI command receiver: shifts host frames into a register, validates them,
// updates per-channel shadow codes and commits all shadows to data_out at once.
module dac_cmd_rx #(
    parameter int unsigned CH_NUM    = dac_pkg::CH_NUM,
    parameter int unsigned DAC_W     = dac_pkg::DAC_W,
    parameter int unsigned FRAME_LEN = dac_pkg::FRAME_LEN,
    parameter int unsigned MIDSCALE  = dac_pkg::MIDSCALE
) (
    input  logic                          clk_core,
    input  logic                          rst_n,
    input  logic                          spi_sclk,
    input  logic                          spi_mosi,
    input  logic                          spi_cs_n,
    output logic [CH_NUM-1:0][DAC_W-1:0]  data_out,
    output logic                          update_en,
    output logic                          busy,
    output logic                          frame_err
);

    import dac_pkg::*;

    localparam int unsigned      CNT_W    = $clog2(FRAME_LEN + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_LEN + 1);
    localparam logic [DAC_W-1:0] MID_CODE = DAC_W'(MIDSCALE);

    logic sclk_lvl, sclk_rise_c, sclk_fall_c;
    logic mosi_lvl, mosi_rise_c, mosi_fall_c;
    logic cs_lvl, cs_rise_c, cs_fall_c;
    logic sync_unused_c;

    spi_sync_edge #(.RST_VAL(1'b0)) u_sync_sclk (
        .clk_core (clk_core),
        .rst_n    (rst_n),
        .din      (spi_sclk),
        .dout     (sclk_lvl),
        .rise_c   (sclk_rise_c),
        .fall_c   (sclk_fall_c)
    );

    spi_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
        .clk_core (clk_core),
        .rst_n    (rst_n),
        .din      (spi_mosi),
        .dout     (mosi_lvl),
        .rise_c   (mosi_rise_c),
        .fall_c   (mosi_fall_c)
    );

    spi_sync_edge #(.RST_VAL(1'b1)) u_sync_cs (
        .clk_core (clk_core),
        .rst_n    (rst_n),
        .din      (spi_cs_n),
        .dout     (cs_lvl),
        .rise_c   (cs_rise_c),
        .fall_c   (cs_fall_c)
    );

    // Only sclk rise, mosi level and cs_n edges drive the receiver
    assign sync_unused_c = ^{sclk_lvl, sclk_fall_c, mosi_rise_c, mosi_fall_c, cs_lvl};

    state_e                       state_q, state_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic [FRAME_LEN-1:0]         shreg_q, shreg_d;
    logic [CH_NUM-1:0][DAC_W-1:0] shadow_q, shadow_d;
    logic [CH_NUM-1:0][DAC_W-1:0] data_d;
    logic                         update_en_d;
    logic                         frame_err_d;
    logic                         busy_d;

    frame_t frm_c;
    logic   bcast_c;
    logic   ch_ok_c;

    assign frm_c   = frame_t'(shreg_q);
    assign bcast_c = (frm_c.ch == CH_BCAST);
    assign ch_ok_c = bcast_c || (32'(frm_c.ch) < CH_NUM);

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        shadow_d    = shadow_q;
        data_d      = data_out;
        update_en_d = 1'b0;
        frame_err_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cs_fall_c) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                end
            end

            SHIFT: begin
                // A coincident sclk rise is shifted and counted before the length check
                if (sclk_rise_c) begin
                    shreg_d = {shreg_q[FRAME_LEN-2:0], mosi_lvl};
                    if (cnt_q != CNT_SAT) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                if (cs_rise_c) begin
                    if (cnt_d == CNT_FULL) begin
                        state_d = CHECK;
                    end else begin
                        state_d     = IDLE;
                        frame_err_d = 1'b1;
                    end
                end
            end

            CHECK: begin
                if (!ch_ok_c) begin
                    state_d     = IDLE;
                    frame_err_d = 1'b1;
                end else begin
                    if (frm_c.op != OP_COMMIT) begin
                        for (int unsigned i = 0; i < CH_NUM; i++) begin
                            if (bcast_c || (32'(frm_c.ch) == i)) begin
                                shadow_d[i] = (frm_c.op == OP_MID) ? MID_CODE : frm_c.value;
                            end
                        end
                    end
                    state_d = (frm_c.op == OP_WR) ? IDLE : COMMIT;
                end
            end

            COMMIT: begin
                data_d      = shadow_q;
                update_en_d = 1'b1;
                state_d     = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and registered outputs
    always_ff @(posedge clk_core or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shreg_q   <= '0;
            shadow_q  <= {CH_NUM{MID_CODE}};
            data_out  <= {CH_NUM{MID_CODE}};
            update_en <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shreg_q   <= shreg_d;
            shadow_q  <= shadow_d;
            data_out  <= data_d;
            update_en <= update_en_d;
            frame_err <= frame_err_d;
            busy      <= busy_d;
        end
    end

endmodule

// File: tb/tb_dac_cmd_rx.sv
// Self-checking bench for dac_cmd_rx: directed frames plus randomized frames
// compared against a frame-level reference model of the shadow/commit behaviour.
module tb_dac_cmd_rx;

    localparam int CH  = 3;
    localparam int W   = 12;
    localparam int MID = 2048;

    typedef logic [CH-1:0][W-1:0] dvec_t;

    typedef struct {
        int    upd_cnt;
        int    upd_idx;
        int    err_cnt;
        logic  busy_mid;
        logic  busy_end;
        dvec_t d_pre;
        dvec_t d_at;
        dvec_t d_end;
    } obs_t;

    logic  clk_core;
    logic  rst_n;
    logic  spi_sclk;
    logic  spi_mosi;
    logic  spi_cs_n;
    dvec_t data_out;
    logic  update_en;
    logic  busy;
    logic  frame_err;

    int total;
    int bad;

    int unsigned m_shadow[CH];
    int unsigned m_out[CH];

    dac_cmd_rx dut (
        .clk_core  (clk_core),
        .rst_n     (rst_n),
        .spi_sclk  (spi_sclk),
        .spi_mosi  (spi_mosi),
        .spi_cs_n  (spi_cs_n),
        .data_out  (data_out),
        .update_en (update_en),
        .busy      (busy),
        .frame_err (frame_err)
    );

    initial clk_core = 1'b0;
    always #5 clk_core = ~clk_core;

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            m_shadow[i] = MID;
            m_out[i]    = MID;
        end
    endtask

    // Frame-level behaviour: length check, channel check, then opcode effect
    task automatic model_frame(input logic [31:0] word, input int nbits,
                               output bit commit, output bit err);
        int unsigned ch, op, v;
        commit = 1'b0;
        err    = 1'b0;
        if (nbits != 16) begin
            err = 1'b1;
            return;
        end
        ch = (word >> 14) & 3;
        op = (word >> 12) & 3;
        v  = word & 32'hFFF;
        if (ch != 3 && ch >= CH) begin
            err = 1'b1;
            return;
        end
        if (op != 2) begin
            for (int i = 0; i < CH; i++) begin
                if (ch == 3 || ch == i) m_shadow[i] = (op == 3) ? MID : v;
            end
        end
        if (op != 0) begin
            commit = 1'b1;
            for (int i = 0; i < CH; i++) m_out[i] = m_shadow[i];
        end
    endtask

    function automatic dvec_t exp_vec();
        dvec_t v;
        for (int i = 0; i < CH; i++) v[i] = W'(m_out[i]);
        return v;
    endfunction

    // Drives one frame; k=0 is the first clk_core edge that samples cs_n high
    task automatic drive_frame(input logic [31:0] word, input int nbits,
                               input bit coincide, output obs_t o);
        o.upd_cnt  = 0;
        o.upd_idx  = -1;
        o.err_cnt  = 0;
        o.busy_mid = 1'b0;
        @(negedge clk_core);
        spi_cs_n = 1'b0;
        repeat (4) @(negedge clk_core);
        for (int i = nbits - 1; i >= 0; i--) begin
            spi_mosi = word[i];
            repeat (4) @(negedge clk_core);
            if (i == nbits / 2) o.busy_mid = busy;
            spi_sclk = 1'b1;
            if (i == 0 && coincide) begin
                spi_cs_n = 1'b1;
            end else begin
                repeat (4) @(negedge clk_core);
                spi_sclk = 1'b0;
            end
        end
        if (!coincide) begin
            repeat (2) @(negedge clk_core);
            spi_cs_n = 1'b1;
        end
        for (int k = 0; k <= 10; k++) begin
            @(posedge clk_core);
            #1;
            if (update_en === 1'b1) begin
                o.upd_cnt++;
                if (o.upd_cnt == 1) o.upd_idx = k;
            end
            if (frame_err === 1'b1) o.err_cnt++;
            if (k == 3) o.d_pre = data_out;
            if (k == 4) o.d_at = data_out;
        end
        o.busy_end = busy;
        o.d_end    = data_out;
        @(negedge clk_core);
        spi_sclk = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk_core);
        rst_n = 1'b0;
        repeat (2) @(negedge clk_core);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        dvec_t e;
        rst_n    = 1'b0;
        spi_sclk = 1'b0;
        spi_mosi = 1'b0;
        spi_cs_n = 1'b1;
        model_reset();
        repeat (3) @(posedge clk_core);
        #1;
        e = exp_vec();
        total++; if (data_out !== e)      begin bad++; $display("FAIL reset_data_out: got %h exp %h", data_out, e); end
        total++; if (update_en !== 1'b0)  begin bad++; $display("FAIL reset_update_en: got %b exp 0", update_en); end
        total++; if (frame_err !== 1'b0)  begin bad++; $display("FAIL reset_frame_err: got %b exp 0", frame_err); end
        total++; if (busy !== 1'b0)       begin bad++; $display("FAIL reset_busy: got %b exp 0", busy); end
        @(negedge clk_core);
        rst_n = 1'b1;
    endtask

    task automatic test_write_commit();
        obs_t o;
        dvec_t old_v, e;
        bit c, er;
        old_v = exp_vec();
        model_frame(32'h1ABC, 16, c, er);
        e = exp_vec();
        drive_frame(32'h1ABC, 16, 1'b0, o);
        total++; if (o.upd_cnt != 1)  begin bad++; $display("FAIL wc_upd_cnt: got %0d exp 1", o.upd_cnt); end
        total++; if (o.upd_idx != 4)  begin bad++; $display("FAIL wc_latency: got %0d exp 4", o.upd_idx); end
        total++; if (o.d_pre !== old_v) begin bad++; $display("FAIL wc_data_before: got %h exp %h", o.d_pre, old_v); end
        total++; if (o.d_at !== e)    begin bad++; $display("FAIL wc_data_commit: got %h exp %h", o.d_at, e); end
        total++; if (o.err_cnt != 0)  begin bad++; $display("FAIL wc_err_cnt: got %0d exp 0", o.err_cnt); end
        total++; if (o.busy_mid !== 1'b1) begin bad++; $display("FAIL wc_busy_mid: got %b exp 1", o.busy_mid); end
        total++; if (o.busy_end !== 1'b0) begin bad++; $display("FAIL wc_busy_end: got %b exp 0", o.busy_end); end
    endtask

    task automatic test_commit_only();
        obs_t o;
        dvec_t old_v, e;
        logic [31:0] frames [3];
        bit c, er;
        frames[0] = 32'h4100;
        frames[1] = 32'h8200;
        frames[2] = 32'h2000;
        apply_reset();
        for (int f = 0; f < 2; f++) begin
            old_v = exp_vec();
            model_frame(frames[f], 16, c, er);
            drive_frame(frames[f], 16, 1'b0, o);
            total++; if (o.upd_cnt != 0) begin bad++; $display("FAIL shadow_only_upd[%0d]: got %0d exp 0", f, o.upd_cnt); end
            total++; if (o.d_end !== old_v) begin bad++; $display("FAIL shadow_only_data[%0d]: got %h exp %h", f, o.d_end, old_v); end
        end
        old_v = exp_vec();
        model_frame(frames[2], 16, c, er);
        e = exp_vec();
        drive_frame(frames[2], 16, 1'b0, o);
        total++; if (e !== {12'h200, 12'h100, 12'h800}) begin bad++; $display("FAIL commit_model: got %h exp %h", e, {12'h200, 12'h100, 12'h800}); end
        total++; if (o.d_pre !== old_v) begin bad++; $display("FAIL commit_before: got %h exp %h", o.d_pre, old_v); end
        total++; if (o.d_at !== e)      begin bad++; $display("FAIL commit_data: got %h exp %h", o.d_at, e); end
        total++; if (o.upd_cnt != 1 || o.upd_idx != 4) begin bad++; $display("FAIL commit_upd: got cnt %0d idx %0d exp cnt 1 idx 4", o.upd_cnt, o.upd_idx); end
    endtask

    task automatic test_broadcast_mid();
        obs_t o;
        dvec_t e;
        bit c, er;
        model_frame(32'h1555, 16, c, er);
        drive_frame(32'h1555, 16, 1'b0, o);
        e = exp_vec();
        total++; if (o.d_end !== e) begin bad++; $display("FAIL bc_pre_write: got %h exp %h", o.d_end, e); end
        model_frame(32'hF000, 16, c, er);
        e = exp_vec();
        drive_frame(32'hF000, 16, 1'b0, o);
        total++; if (o.d_at !== {CH{12'h800}}) begin bad++; $display("FAIL bc_midscale: got %h exp %h", o.d_at, {CH{12'h800}}); end
        total++; if (o.d_end !== e) begin bad++; $display("FAIL bc_model: got %h exp %h", o.d_end, e); end
        total++; if (o.upd_cnt != 1) begin bad++; $display("FAIL bc_upd_cnt: got %0d exp 1", o.upd_cnt); end
    endtask

    task automatic test_bad_length();
        obs_t o;
        dvec_t old_v;
        int lens [2];
        lens[0] = 15;
        lens[1] = 17;
        for (int j = 0; j < 2; j++) begin
            old_v = exp_vec();
            drive_frame(32'h1_3777, lens[j], 1'b0, o);
            total++; if (o.err_cnt != 1) begin bad++; $display("FAIL len%0d_err: got %0d exp 1", lens[j], o.err_cnt); end
            total++; if (o.upd_cnt != 0) begin bad++; $display("FAIL len%0d_upd: got %0d exp 0", lens[j], o.upd_cnt); end
            total++; if (o.d_end !== old_v) begin bad++; $display("FAIL len%0d_data: got %h exp %h", lens[j], o.d_end, old_v); end
        end
    endtask

    task automatic test_coincident_edges();
        obs_t o;
        dvec_t e;
        bit c, er;
        model_frame(32'h2000 | 32'h0, 16, c, er);
        model_frame(32'h5A5A, 16, c, er);
        e = exp_vec();
        drive_frame(32'h5A5A, 16, 1'b1, o);
        total++; if (o.err_cnt != 0) begin bad++; $display("FAIL coincide_err: got %0d exp 0", o.err_cnt); end
        total++; if (o.d_end !== e)  begin bad++; $display("FAIL coincide_data: got %h exp %h", o.d_end, e); end
        total++; if (o.upd_idx != 4) begin bad++; $display("FAIL coincide_latency: got %0d exp 4", o.upd_idx); end
    endtask

    task automatic test_reset_mid_frame();
        obs_t o;
        dvec_t e;
        logic [15:0] w;
        int upd, err;
        bit c, er;
        w = 16'h1123;
        @(negedge clk_core);
        spi_cs_n = 1'b0;
        repeat (4) @(negedge clk_core);
        for (int i = 15; i >= 8; i--) begin
            spi_mosi = w[i];
            repeat (4) @(negedge clk_core);
            spi_sclk = 1'b1;
            repeat (4) @(negedge clk_core);
            spi_sclk = 1'b0;
        end
        repeat (2) @(negedge clk_core);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL midrst_busy_before: got %b exp 1", busy); end
        rst_n    = 1'b0;
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        model_reset();
        e = exp_vec();
        @(posedge clk_core);
        #1;
        total++; if (data_out !== e)     begin bad++; $display("FAIL midrst_data: got %h exp %h", data_out, e); end
        total++; if (busy !== 1'b0)      begin bad++; $display("FAIL midrst_busy: got %b exp 0", busy); end
        total++; if (update_en !== 1'b0 || frame_err !== 1'b0) begin bad++; $display("FAIL midrst_pulses: got upd %b err %b exp 0 0", update_en, frame_err); end
        repeat (2) @(negedge clk_core);
        rst_n = 1'b1;
        upd = 0;
        err = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk_core);
            #1;
            if (update_en === 1'b1) upd++;
            if (frame_err === 1'b1) err++;
        end
        total++; if (upd != 0 || err != 0) begin bad++; $display("FAIL midrst_after: got upd %0d err %0d exp 0 0", upd, err); end
        model_frame(32'h1123, 16, c, er);
        e = exp_vec();
        drive_frame(32'h1123, 16, 1'b0, o);
        total++; if (o.d_end !== e || o.d_end[0] !== 12'h123) begin bad++; $display("FAIL midrst_refill: got %h exp %h", o.d_end, e); end
        total++; if (o.upd_cnt != 1) begin bad++; $display("FAIL midrst_refill_upd: got %0d exp 1", o.upd_cnt); end
    endtask

    task automatic test_random();
        obs_t o;
        dvec_t old_v, e;
        logic [31:0] word;
        int nbits, r;
        bit coincide, c, er;
        for (int n = 0; n < 30; n++) begin
            word     = $urandom;
            r        = $urandom_range(0, 9);
            nbits    = (r == 0) ? 15 : (r == 1) ? 17 : 16;
            coincide = 1'($urandom_range(0, 1));
            old_v    = exp_vec();
            model_frame(word, nbits, c, er);
            e = exp_vec();
            drive_frame(word, nbits, coincide, o);
            total++; if (o.upd_cnt != int'(c)) begin bad++; $display("FAIL rnd%0d_upd: got %0d exp %0d (word %h bits %0d)", n, o.upd_cnt, c, word, nbits); end
            total++; if (o.err_cnt != int'(er)) begin bad++; $display("FAIL rnd%0d_err: got %0d exp %0d (word %h bits %0d)", n, o.err_cnt, er, word, nbits); end
            total++; if (o.d_pre !== old_v) begin bad++; $display("FAIL rnd%0d_before: got %h exp %h", n, o.d_pre, old_v); end
            total++; if (o.d_end !== e) begin bad++; $display("FAIL rnd%0d_data: got %h exp %h (word %h bits %0d)", n, o.d_end, e, word, nbits); end
            if (c) begin
                total++; if (o.upd_idx != 4 || o.d_at !== e) begin bad++; $display("FAIL rnd%0d_commit_edge: got idx %0d data %h exp idx 4 data %h", n, o.upd_idx, o.d_at, e); end
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_write_commit();
        test_commit_only();
        test_broadcast_mid();
        test_bad_length();
        test_coincident_edges();
        test_reset_mid_frame();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
